// File: rtl/shift_pkg.sv
// Shared encodings for the multi-cycle shifter: operation codes and FSM states.
package shift_pkg;

  // Shift operation select, as driven on the op port.
  typedef enum logic [1:0] {
    SH_SLL  = 2'b00,
    SH_SRL  = 2'b01,
    SH_SRA  = 2'b10,
    SH_PASS = 2'b11
  } shift_op_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/seq_shifter.sv
// Bit-serial shifter: one bit position per clock. Supports sll, srl, sra and pass-through.
// result/carry track the working register and stay stable from DONE until the next accepted start.
module seq_shifter
  import shift_pkg::*;
#(
  parameter int DW  = 32,
  parameter int SHW = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic [DW-1:0]  data_in,
  input  logic [SHW-1:0] shamt,
  output logic [DW-1:0]  result,
  output logic           carry,
  output logic           busy,
  output logic           done
);

  state_e         state_q, state_d;
  shift_op_e      op_q, op_d;
  logic [DW-1:0]  work_q, work_d;
  logic           carry_q, carry_d;
  logic [SHW-1:0] cnt_q, cnt_d;

  // One-bit shift step; returns {shifted_out_bit, new_word}.
  function automatic logic [DW:0] shift_step(input shift_op_e sop, input logic [DW-1:0] w);
    logic [DW:0] r;
    case (sop)
      SH_SLL:  r = {w[DW-1], w[DW-2:0], 1'b0};
      SH_SRL:  r = {w[0], 1'b0, w[DW-1:1]};
      SH_SRA:  r = {w[0], w[DW-1], w[DW-1:1]};
      default: r = {1'b0, w};
    endcase
    return r;
  endfunction

  // Next-state and output decode; every target starts from its held value.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    work_d  = work_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = data_in;
          cnt_d   = shamt;
          op_d    = shift_op_e'(op);
          carry_d = 1'b0;
          if (shamt == '0 || shift_op_e'(op) == SH_PASS) begin
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        busy = 1'b1;
        {carry_d, work_d} = shift_step(op_q, work_q);
        // Guarded so the counter can never wrap below zero.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - SHW'(1);
        end
        if (cnt_q <= SHW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= SH_SLL;
      work_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      work_q  <= work_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign result = work_q;
  assign carry  = carry_q;

endmodule

// File: doc/seq_shifter.md
Name: seq_shifter

Overview:
- Multi-cycle shift unit in the KGP_RISC execute stage; shifts one bit position per clock.
- Handles logical left, logical right and arithmetic right shifts of a 32-bit operand by a 5-bit amount.
- Sits directly upstream of the 32-bit writeback select mux: result drives the mux in1 leg, and done qualifies the select.
- Also produces the shift-out carry for the processor carry flag.

Parameters:
- DW, 32, data width.
- SHW, 5, shift-amount width; the maximum shift is 2^SHW-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a shift; sampled only in IDLE.
- op  input  2  00 sll, 01 srl, 10 sra, 11 pass-through.
- data_in  input  DW  operand; captured when start is accepted.
- shamt  input  SHW  shift amount; captured when start is accepted.
- result  output  DW  shifted value; holds until the next accepted start.
- carry  output  1  last bit shifted out.
- busy  output  1  high from the cycle after acceptance until done.
- done  output  1  one-cycle pulse; result and carry are valid.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high (ports clk, rst).
  - On rst: state IDLE, result=0, carry=0, busy=0, done=0, counter=0.
  - Applies immediately, including mid-shift; the in-flight operation is discarded and no done is issued.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0, done=0.
  - With start=1 at an edge, capture data_in into the working register, shamt into the counter, and op.
  - If shamt=0 or op=11, go to DONE with result=data_in and carry=0.
  - Otherwise go to SHIFT.
- SHIFT:
  - busy=1.
  - Each edge shifts the working register by one bit:
    - sll: insert 0 at bit 0; carry gets the old bit DW-1.
    - srl: insert 0 at bit DW-1; carry gets the old bit 0.
    - sra: replicate bit DW-1; carry gets the old bit 0.
  - Each edge also decrements the counter. When the counter is 1 at the edge, go to DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then return to IDLE.
- Latency: with start accepted at edge 0, done is high in the cycle after edge shamt (shamt=0 or op=11: the cycle after edge 0). That is shamt+1 cycles.
- start in SHIFT or DONE is ignored: no queuing, and the operation in flight is unaffected.
- Input changes after acceptance have no effect.
- result and carry update during SHIFT.
  - Consumers use them only when done=1 or in the IDLE that follows.
  - Both are stable from DONE until the next accepted start.
- shamt=31 with sra leaves all bits equal to the original sign bit.
- No wrap-around: the counter never underflows, because it decrements only in SHIFT while the counter is 1 or more.

Decomposition:
- Shared package shift_pkg:
  - op encodings SH_SLL=2'b00, SH_SRL=2'b01, SH_SRA=2'b10, SH_PASS=2'b11.
  - state encoding IDLE/SHIFT/DONE.
- Single flat module; no sub-module warranted. The one-bit shift step is a local combinational function.

Test Plan:
- sll, data_in=0x0000_0001, shamt=4 -> done 5 cycles after acceptance; result=0x0000_0010, carry=0; busy high for exactly 4 cycles.
- srl, data_in=0xF000_000F, shamt=1 -> done 2 cycles after acceptance; result=0x7800_0007, carry=1.
- sra, data_in=0x8000_0000, shamt=31 -> done 32 cycles after acceptance; result=0xFFFF_FFFF, carry=0.
  - sra, data_in=0x8000_0001, shamt=1 -> result=0xC000_0000, carry=1.
- shamt=0 (op=sll) and op=11 (shamt=7), data_in=0xDEAD_BEEF -> done the next cycle; result=0xDEAD_BEEF, carry=0; busy never asserts.
- Accept sll of 0x1 by 8, pulse start with data_in=0xFFFF_FFFF in the 3rd SHIFT cycle -> ignored; a single done pulse; result=0x0000_0100, carry=0.
- Assert rst asynchronously mid-cycle during the 5th SHIFT cycle of a 10-bit shift -> immediate result=0, carry=0, busy=0, and no done.
  - After release, a new start (srl 0x80 by 7) -> result=0x1, carry=0.
